// File: rtl/pipeline_multiplication.sv
// rtl/pipeline_multiplication.sv - pipelined shift-add multiply-accumulate: dividend = quotient * divisor + remainder
//
// Rebuilds a dividend from a divider's quotient/remainder pair. One operand set
// is accepted per clock; results emerge QUOTIENT_WIDTH+1 clocks later in order.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset, clears every pipeline register
//   quotient_i   multiplier operand (unsigned, QUOTIENT_WIDTH)
//   divisor_i    multiplicand operand (unsigned, DIVISOR_WIDTH)
//   remainder_i  addend (unsigned, DIVISOR_WIDTH)
//   valid_i      operand set valid this cycle
//   dividend_o   quotient*divisor+remainder, exact (QUOTIENT_WIDTH+DIVISOR_WIDTH)
//   fits_o       result fits in QUOTIENT_WIDTH bits
//   rem_ok_o     captured remainder < captured divisor
//   valid_o      outputs valid this cycle

module pipeline_multiplication #(
    parameter int QUOTIENT_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [QUOTIENT_WIDTH-1:0]               quotient_i,
    input  logic [DIVISOR_WIDTH-1:0]                divisor_i,
    input  logic [DIVISOR_WIDTH-1:0]                remainder_i,
    input  logic                                    valid_i,
    output logic [QUOTIENT_WIDTH+DIVISOR_WIDTH-1:0] dividend_o,
    output logic                                    fits_o,
    output logic                                    rem_ok_o,
    output logic                                    valid_o
);

    localparam int QW = QUOTIENT_WIDTH;
    localparam int DW = DIVISOR_WIDTH;
    localparam int AW = QUOTIENT_WIDTH + DIVISOR_WIDTH;

    // Stage k holds the sum of remainder and the partial products of quotient
    // bits [k-1:0]. Quotient/divisor copies are only needed up to stage QW-1.
    logic [AW-1:0] acc_q  [0:QW];
    logic [QW-1:0] quo_q  [0:QW-1];
    logic [DW-1:0] div_q  [0:QW-1];
    logic          ok_q   [0:QW];
    logic          vld_q  [0:QW];

    // Partial product for stage k: divisor, zero-extended to the accumulator
    // width, shifted to the weight of quotient bit k-1.
    logic [AW-1:0] addend [1:QW];

    for (genvar k = 1; k <= QW; k++) begin : g_addend
        assign addend[k] = quo_q[k-1][k-1]
                         ? ({{QW{1'b0}}, div_q[k-1]} << (k - 1))
                         : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k <= QW; k++) begin
                acc_q[k] <= '0;
                ok_q[k]  <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            for (int k = 0; k < QW; k++) begin
                quo_q[k] <= '0;
                div_q[k] <= '0;
            end
            dividend_o <= '0;
            fits_o     <= 1'b0;
            rem_ok_o   <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            // Input capture is unconditional; valid alone qualifies the data.
            acc_q[0] <= {{QW{1'b0}}, remainder_i};
            quo_q[0] <= quotient_i;
            div_q[0] <= divisor_i;
            ok_q[0]  <= (remainder_i < divisor_i);
            vld_q[0] <= valid_i;

            for (int k = 1; k <= QW; k++) begin
                // Max sum is 2^QW*(2^DW-1), so the add never carries out of AW.
                acc_q[k] <= acc_q[k-1] + addend[k];
                ok_q[k]  <= ok_q[k-1];
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 1; k < QW; k++) begin
                quo_q[k] <= quo_q[k-1];
                div_q[k] <= div_q[k-1];
            end

            dividend_o <= acc_q[QW];
            fits_o     <= (acc_q[QW][AW-1:QW] == '0);
            rem_ok_o   <= ok_q[QW];
            valid_o    <= vld_q[QW];
        end
    end

endmodule
